line_option_gen: RTL and testbench

LINE_OPTION_GEN -- requirements
Module: line_option_gen

---
 rtl/nonogram_pkg.sv | 10 +
 rtl/line_mask_builder.sv | 20 ++
 rtl/line_option_gen.sv | 124 ++++++++++++
 tb/tb_line_option_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// nonogram_pkg: board limits and line generator state encoding shared across the nonogram blocks.
package nonogram_pkg;
  localparam int MAX_ROWS = 11;
  localparam int MAX_COLS = 11;
  localparam int MAX_CLUES = 6;
  localparam int MAX_NUM_OPTIONS = 84;
  localparam int OPT_W = 16;
  localparam int LARGEST_DIM = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS;
  typedef enum logic [1:0] {IDLE, HEADER, EMIT, DONE} state_e;
endpackage

// File: rtl/line_mask_builder.sv
// line_mask_builder: turns block start positions into a cell mask (bit c set iff a block covers cell c).
module line_mask_builder #(
  parameter int MAX_CLUES = nonogram_pkg::MAX_CLUES,
  parameter int OPT_W = nonogram_pkg::OPT_W
) (
  input  logic [MAX_CLUES-1:0][3:0] pos_i,
  input  logic [MAX_CLUES-1:0][3:0] clues_i,
  input  logic [2:0]                clue_cnt_i,
  input  logic [3:0]                line_len_i,
  output logic [OPT_W-1:0]          mask_o
);
  always_comb begin
    mask_o = '0;
    for (int c = 0; c < OPT_W; c++)
      for (int i = 0; i < MAX_CLUES; i++)
        if (3'(i) < clue_cnt_i && c < int'(line_len_i) && c >= int'(pos_i[i]) &&
            c < int'(pos_i[i]) + int'(clues_i[i]))
          mask_o[c] = 1'b1;
  end
endmodule

// File: rtl/line_option_gen.sv
// line_option_gen: streams a header word and every legal block placement mask for one nonogram line,
// then writes the option count into the count table.
module line_option_gen #(
  parameter int MAX_ROWS = nonogram_pkg::MAX_ROWS,
  parameter int MAX_COLS = nonogram_pkg::MAX_COLS,
  parameter int MAX_CLUES = nonogram_pkg::MAX_CLUES,
  parameter int MAX_NUM_OPTIONS = nonogram_pkg::MAX_NUM_OPTIONS,
  parameter int OPT_W = nonogram_pkg::OPT_W,
  localparam int IW = $clog2(MAX_ROWS + MAX_COLS),
  localparam int CW = $clog2(MAX_NUM_OPTIONS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IW-1:0]             line_index,
  input  logic [3:0]                line_len,
  input  logic [2:0]                clue_cnt,
  input  logic [MAX_CLUES-1:0][3:0] clues,
  output logic                      busy,
  output logic                      opt_valid,
  output logic [OPT_W-1:0]          opt_data,
  input  logic                      opt_ready,
  output logic                      cnt_we,
  output logic [IW-1:0]             cnt_index,
  output logic [CW-1:0]             cnt_value,
  output logic                      err
);
  import nonogram_pkg::*;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0] len_q, len_d;
  logic [2:0] cnt_q, cnt_d, k;
  logic [MAX_CLUES-1:0][3:0] clues_q, clues_d, pos_q, pos_d, init_pos, adv_pos;
  logic [CW-1:0] count_q, count_d;
  logic err_q, err_d, fit_err, movable;
  logic [7:0] need;
  logic [OPT_W-1:0] mask;
  line_mask_builder #(.MAX_CLUES(MAX_CLUES), .OPT_W(OPT_W)) u_mask (
    .pos_i(pos_q), .clues_i(clues_q), .clue_cnt_i(cnt_q), .line_len_i(len_q), .mask_o(mask)
  );
  // Leftmost packing and fit test are taken straight from the inputs at capture time.
  always_comb begin
    init_pos = '0;
    need = 8'(clue_cnt) - 8'd1;
    for (int i = 1; i < MAX_CLUES; i++)
      init_pos[i] = init_pos[i-1] + clues[i-1] + 4'd1;
    for (int i = 0; i < MAX_CLUES; i++)
      if (3'(i) < clue_cnt) need = need + 8'(clues[i]);
    fit_err = clue_cnt != 3'd0 && need > 8'(line_len);
  end
  // Highest movable block steps right by one; everything after it repacks leftmost.
  always_comb begin
    movable = 1'b0;
    k = '0;
    for (int i = 0; i < MAX_CLUES; i++)
      if (3'(i) < cnt_q && (3'(i) == cnt_q - 3'd1 ?
          5'(pos_q[i]) + 5'(clues_q[i]) < 5'(len_q) :
          5'(pos_q[i]) + 5'(clues_q[i]) + 5'd1 < 5'(pos_q[(i+1) % MAX_CLUES]))) begin
        movable = 1'b1;
        k = 3'(i);
      end
    adv_pos = pos_q;
    for (int i = 0; i < MAX_CLUES; i++)
      if (3'(i) == k) adv_pos[i] = pos_q[i] + 4'd1;
      else if (3'(i) > k)
        adv_pos[i] = adv_pos[(i+MAX_CLUES-1) % MAX_CLUES] + clues_q[(i+MAX_CLUES-1) % MAX_CLUES] + 4'd1;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    cnt_d = cnt_q;
    clues_d = clues_q;
    pos_d = pos_q;
    count_d = count_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HEADER;
        idx_d = line_index;
        len_d = line_len;
        cnt_d = clue_cnt;
        clues_d = clues;
        pos_d = init_pos;
        count_d = '0;
        err_d = fit_err;
      end
      HEADER: if (opt_ready) state_d = err_q ? DONE : EMIT;
      EMIT: if (opt_ready) begin
        count_d = count_q == CW'(MAX_NUM_OPTIONS) ? count_q : count_q + CW'(1);
        pos_d = movable ? adv_pos : pos_q;
        state_d = movable ? EMIT : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      clues_q <= '0;
      pos_q <= '0;
      count_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      clues_q <= clues_d;
      pos_q <= pos_d;
      count_q <= count_d;
      err_q <= err_d;
    end
  assign busy = state_q != IDLE;
  assign opt_valid = state_q == HEADER || state_q == EMIT;
  assign opt_data = state_q == HEADER ? OPT_W'(idx_q) : state_q == EMIT ? mask : '0;
  assign cnt_we = state_q == DONE;
  assign cnt_index = idx_q;
  assign cnt_value = count_q;
  assign err = err_q;
endmodule

// File: tb/tb_line_option_gen.sv
// tb_line_option_gen: randomized and directed checks of line_option_gen against a brute-force placement model.
module tb_line_option_gen;
  import nonogram_pkg::*;
  localparam int IW = $clog2(MAX_ROWS + MAX_COLS);
  localparam int CW = $clog2(MAX_NUM_OPTIONS);
  typedef logic [MAX_CLUES-1:0][3:0] clues_t;
  typedef struct {int idx; int len; int cnt; int pct; bit poke; clues_t cl;} row_t;
  logic clk = 1'b0, rst, start, opt_ready, busy, opt_valid, cnt_we, err;
  logic [IW-1:0] line_index, cnt_index;
  logic [3:0] line_len;
  logic [2:0] clue_cnt;
  clues_t clues;
  logic [OPT_W-1:0] opt_data;
  logic [CW-1:0] cnt_value;
  int checks = 0, failures = 0;
  logic [OPT_W-1:0] got[$], exp_q[$];
  int got_cnt, got_idx, exp_count, stall_bad, gaps;
  bit got_err, err_cap, busy_cap, exp_err, timed_out, busy_after, we_after;
  row_t rows[$];

  line_option_gen dut (
    .clk(clk), .rst(rst), .start(start), .line_index(line_index), .line_len(line_len),
    .clue_cnt(clue_cnt), .clues(clues), .busy(busy), .opt_valid(opt_valid), .opt_data(opt_data),
    .opt_ready(opt_ready), .cnt_we(cnt_we), .cnt_index(cnt_index), .cnt_value(cnt_value), .err(err)
  );

  always #5 clk = ~clk;

  function automatic clues_t mkc(input int a = 0, input int b = 0, input int c = 0);
    clues_t v = '0;
    v[0] = 4'(a);
    v[1] = 4'(b);
    v[2] = 4'(c);
    return v;
  endfunction

  // Enumerate every cell pattern, keep those whose runs match the clues, order by start positions.
  task automatic model_line(input int len, input int cnt, input clues_t cl);
    longint keys[$];
    longint key;
    int c, st, runs, ins, sum;
    bit ok;
    exp_q.delete();
    for (int m = 0; m < (1 << len); m++) begin
      c = 0;
      runs = 0;
      ok = 1;
      key = 0;
      while (c < len) begin
        if (((m >> c) & 1) == 1) begin
          st = c;
          while (c < len && ((m >> c) & 1) == 1) c++;
          if (runs >= cnt || c - st != int'(cl[runs])) ok = 0;
          else key = key * 16 + st;
          runs++;
        end else c++;
      end
      if (ok && runs == cnt) begin
        ins = keys.size();
        for (int j = keys.size() - 1; j >= 0; j--) if (keys[j] > key) ins = j;
        keys.insert(ins, key);
        exp_q.insert(ins, OPT_W'(m));
      end
    end
    sum = 0;
    for (int i = 0; i < cnt; i++) sum += int'(cl[i]);
    exp_err = cnt > 0 && sum + cnt - 1 > len;
    exp_count = exp_q.size() > MAX_NUM_OPTIONS ? MAX_NUM_OPTIONS : exp_q.size();
  endtask

  task automatic run_line(input row_t r);
    bit prev_stall = 0, done = 0;
    logic [OPT_W-1:0] prev_data = '0;
    got.delete();
    stall_bad = 0;
    gaps = 0;
    @(negedge clk);
    line_index = IW'(r.idx);
    line_len = 4'(r.len);
    clue_cnt = 3'(r.cnt);
    clues = r.cl;
    start = 1;
    opt_ready = 0;
    @(negedge clk);
    start = 0;
    err_cap = err;
    busy_cap = busy;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 0;
      line_index = IW'(r.idx);
      if (cnt_we) begin
        got_cnt = int'(cnt_value);
        got_idx = int'(cnt_index);
        got_err = err;
        done = 1;
      end else begin
        if (prev_stall && !(opt_valid && opt_data === prev_data)) stall_bad++;
        if (!opt_valid) gaps++;
        if (r.poke && cyc == 2) begin
          start = 1;
          line_index = IW'(r.idx ^ 1);
        end
        opt_ready = $urandom_range(99) < r.pct;
        if (opt_valid && opt_ready) got.push_back(opt_data);
        prev_stall = opt_valid && !opt_ready;
        prev_data = opt_data;
      end
    end
    opt_ready = 0;
    start = 0;
    timed_out = !done;
    @(negedge clk);
    busy_after = busy;
    we_after = cnt_we;
  endtask

  task automatic test_reset;
    rst = 1;
    start = 0;
    opt_ready = 0;
    line_index = '0;
    line_len = '0;
    clue_cnt = '0;
    clues = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, opt_valid, opt_data, cnt_we, cnt_value, cnt_index, err} !== '0)
      begin failures++; $display("FAIL reset_outputs got=%0h exp=0", {busy, opt_valid, opt_data, cnt_we, cnt_value, cnt_index, err}); end
    rst = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_lines(input string tag);
    foreach (rows[n]) begin
      model_line(rows[n].len, rows[n].cnt, rows[n].cl);
      run_line(rows[n]);
      checks++;
      if (timed_out) begin failures++; $display("FAIL %s%0d timeout got=no_cnt_we exp=cnt_we", tag, n); end
      checks++;
      if (got.size() !== exp_q.size() + 1)
        begin failures++; $display("FAIL %s%0d words got=%0d exp=%0d", tag, n, got.size(), exp_q.size() + 1); end
      if (got.size() > 0) begin
        checks++;
        if (got[0] !== OPT_W'(rows[n].idx))
          begin failures++; $display("FAIL %s%0d header got=%0h exp=%0h", tag, n, got[0], rows[n].idx); end
      end
      for (int i = 0; i < exp_q.size() && i + 1 < got.size(); i++) begin
        checks++;
        if (got[i+1] !== exp_q[i])
          begin failures++; $display("FAIL %s%0d opt%0d got=%0h exp=%0h", tag, n, i, got[i+1], exp_q[i]); end
      end
      checks++;
      if (got_cnt !== exp_count) begin failures++; $display("FAIL %s%0d cnt_value got=%0d exp=%0d", tag, n, got_cnt, exp_count); end
      checks++;
      if (got_idx !== rows[n].idx) begin failures++; $display("FAIL %s%0d cnt_index got=%0d exp=%0d", tag, n, got_idx, rows[n].idx); end
      checks++;
      if (got_err !== exp_err || err_cap !== exp_err)
        begin failures++; $display("FAIL %s%0d err got=%0b/%0b exp=%0b", tag, n, err_cap, got_err, exp_err); end
      checks++;
      if (busy_cap !== 1'b1 || busy_after !== 1'b0 || we_after !== 1'b0)
        begin failures++; $display("FAIL %s%0d busy_we got=%0b%0b%0b exp=100", tag, n, busy_cap, busy_after, we_after); end
      checks++;
      if (stall_bad !== 0) begin failures++; $display("FAIL %s%0d stall_hold got=%0d exp=0", tag, n, stall_bad); end
      if (rows[n].pct == 100) begin
        checks++;
        if (gaps !== 0) begin failures++; $display("FAIL %s%0d bubbles got=%0d exp=0", tag, n, gaps); end
      end
    end
  endtask

  task automatic test_mid_reset;
    row_t r = '{idx: 6, len: 5, cnt: 2, pct: 100, poke: 0, cl: mkc(1, 1)};
    int acc = 0, stray = 0;
    @(negedge clk);
    line_index = IW'(r.idx);
    line_len = 4'(r.len);
    clue_cnt = 3'(r.cnt);
    clues = r.cl;
    start = 1;
    opt_ready = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 50 && acc < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (opt_valid && opt_ready) acc++;
    end
    checks++;
    if (acc != 4) begin failures++; $display("FAIL midrst_reach got=%0d exp=4", acc); end
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if ({busy, opt_valid, opt_data, cnt_we, cnt_value, cnt_index, err} !== '0)
      begin failures++; $display("FAIL midrst_outputs got=%0h exp=0", {busy, opt_valid, opt_data, cnt_we, cnt_value, cnt_index, err}); end
    @(negedge clk);
    rst = 0;
    repeat (10) begin
      @(negedge clk);
      if (cnt_we || busy) stray++;
    end
    opt_ready = 0;
    checks++;
    if (stray != 0) begin failures++; $display("FAIL midrst_resume got=%0d exp=0", stray); end
    model_line(r.len, r.cnt, r.cl);
    run_line(r);
    checks++;
    if (got.size() !== exp_q.size() + 1 || got_cnt !== exp_count || timed_out)
      begin failures++; $display("FAIL midrst_rerun got=%0d/%0d exp=%0d/%0d", got.size(), got_cnt, exp_q.size() + 1, exp_count); end
    for (int i = 0; i < exp_q.size() && i + 1 < got.size(); i++) begin
      checks++;
      if (got[i+1] !== exp_q[i]) begin failures++; $display("FAIL midrst_opt%0d got=%0h exp=%0h", i, got[i+1], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    rows.push_back('{idx: 3, len: 5, cnt: 1, pct: 100, poke: 0, cl: mkc(1)});
    rows.push_back('{idx: 4, len: 5, cnt: 2, pct: 100, poke: 0, cl: mkc(1, 1)});
    rows.push_back('{idx: 21, len: 11, cnt: 3, pct: 100, poke: 0, cl: mkc(1, 1, 1)});
    rows.push_back('{idx: 7, len: 6, cnt: 2, pct: 100, poke: 0, cl: mkc(3, 3)});
    rows.push_back('{idx: 9, len: 4, cnt: 0, pct: 100, poke: 0, cl: mkc()});
    rows.push_back('{idx: 5, len: 5, cnt: 2, pct: 45, poke: 0, cl: mkc(1, 1)});
    rows.push_back('{idx: 10, len: 7, cnt: 2, pct: 100, poke: 1, cl: mkc(2, 1)});
    rows.push_back('{idx: 12, len: 5, cnt: 2, pct: 100, poke: 0, cl: mkc(2, 2)});
    rows.push_back('{idx: 1, len: 1, cnt: 1, pct: 100, poke: 0, cl: mkc(1)});
    test_lines("dir");
    rows.delete();
    for (int n = 0; n < 12; n++) begin
      row_t r;
      r.idx = $urandom_range(0, 21);
      r.len = $urandom_range(1, 11);
      r.cnt = $urandom_range(0, 4);
      r.pct = n % 3 == 0 ? 100 : $urandom_range(30, 90);
      r.poke = n % 4 == 1;
      r.cl = '0;
      for (int i = 0; i < r.cnt; i++) r.cl[i] = 4'($urandom_range(1, 4));
      rows.push_back(r);
    end
    test_lines("rnd");
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
